// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants,
// also intended for the companion transmitter.
package uart_pkg;

  localparam int unsigned UartDataBits  = 8;
  localparam logic        UartIdleLevel = 1'b1;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } uart_rx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UartDataBits-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is only ever assigned with <=, so every flop
  // samples the pre-edge value of its neighbours and the chain cannot collapse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, centre-sampled from a down-counting baud timer.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned TICKS_PER_BAUD = 104
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rx_i,
  output logic [UartDataBits-1:0] rx_data_o,
  output logic                    rx_valid_o,
  output logic                    rx_err_o
);

  localparam int unsigned CntW = $clog2(TICKS_PER_BAUD);
  localparam logic [CntW-1:0] CntHalf = CntW'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(TICKS_PER_BAUD - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [2:0]      LastBit = 3'(UartDataBits - 1);

  uart_rx_state_e          state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [UartDataBits-1:0] shift_q, shift_d;
  logic [UartDataBits-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
`ifdef UART_RX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic rx_s;
  logic expiry;

  sync_2ff #(
    .RESET_VAL(UartIdleLevel)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign expiry = (cnt_q == '0);

  always_comb begin
    // NOTE: every _d starts as its _q (pulses start low) so no branch can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (rx_s == 1'b0) begin
          cnt_d   = CntHalf;
          state_d = StStart;
        end
      end

      StStart: begin
        if (!expiry) begin
          cnt_d = cnt_q - CntOne;
        end else if (rx_s == 1'b0) begin
          cnt_d     = CntFull;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          state_d = StIdle;  // start bit vanished by its centre: a glitch
        end
      end

      StData: begin
        if (!expiry) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          shift_d = {rx_s, shift_q[UartDataBits-1:1]};
          cnt_d   = CntFull;
          if (bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!expiry) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          parity_d = rx_s;
          cnt_d    = CntFull;
          state_d  = StStop;
        end
      end
`endif

      StStop: begin
        if (!expiry) begin
          cnt_d = cnt_q - CntOne;
        end else if (rx_s == UartIdleLevel) begin
          state_d = StIdle;
`ifdef UART_RX_PARITY_EN
          if (even_parity(shift_q) != parity_q) begin
            err_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
`else
          data_d  = shift_q;
          valid_d = 1'b1;
`endif
        end else begin
          // Low stop bit: framing error; wait out a possible break.
          err_d   = 1'b1;
          state_d = StWaitIdle;
        end
      end

      StWaitIdle: begin
        if (rx_s == UartIdleLevel) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign rx_err_o   = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner-case sequences and
// randomized frames against a frame-level reference model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int T = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  // Pulse appears one cycle after the stop-bit centre, plus synchronizer lag.
  localparam int Latency = FrameBits * T - T / 2 + 3;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_err_o;

  uart_rx #(
    .TICKS_PER_BAUD(T)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rx_i      (rx_i),
    .rx_data_o (rx_data_o),
    .rx_valid_o(rx_valid_o),
    .rx_err_o  (rx_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       err;
    logic [7:0] data;
    longint     cyc;
  } event_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       flip_par;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  event_t ev_q[$];
  vec_t   vecs[$];
  exp_t   exp_q[$];
  longint cyc = 0;
  longint frame_start = 0;
  int     checks = 0;
  int     failures = 0;
  int     both_cnt = 0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (rx_valid_o) ev_q.push_back('{err: 1'b0, data: rx_data_o, cyc: cyc});
    if (rx_err_o)   ev_q.push_back('{err: 1'b1, data: rx_data_o, cyc: cyc});
    if (rx_valid_o && rx_err_o) both_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    tick(T);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip_par);
    frame_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip_par);
`endif
    drive_bit(stop_bit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] last_good;
    longint     first_cyc;
    longint     k;
    logic [7:0] d;
    logic       stop_ok;
    logic       flip;
    int         n;

    vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5});
    vecs.push_back('{8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b0, 8'h01});
    vecs.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 8'h01});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h00});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 8'h00});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 8'h07});
`endif

    rst_ni = 1'b0;
    rx_i   = 1'b1;
    tick(4);
    check("reset rx_data_o", rx_data_o, 8'h00);
    check("reset rx_valid_o", rx_valid_o, 1'b0);
    check("reset rx_err_o", rx_err_o, 1'b0);
    rst_ni = 1'b1;
    tick(2 * T);

    foreach (vecs[i]) begin
      ev_q.delete();
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].flip_par);
      rx_i = 1'b1;
      tick(2 * T);
      check($sformatf("vec%0d pulse count", i), ev_q.size(), 1);
      if (ev_q.size() > 0) begin
        check($sformatf("vec%0d err flag", i), ev_q[0].err, vecs[i].exp_err);
        check($sformatf("vec%0d data", i), ev_q[0].data, vecs[i].exp_data);
        check($sformatf("vec%0d latency", i), ev_q[0].cyc - frame_start, Latency);
      end
    end

    // Back-to-back frames with no idle gap.
    ev_q.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    first_cyc = frame_start;
    send_frame(8'hFF, 1'b1, 1'b0);
    rx_i = 1'b1;
    tick(2 * T);
    check("b2b pulse count", ev_q.size(), 2);
    if (ev_q.size() >= 2) begin
      check("b2b first data", ev_q[0].data, 8'h00);
      check("b2b second data", ev_q[1].data, 8'hFF);
      check("b2b first err", ev_q[0].err, 1'b0);
      check("b2b second err", ev_q[1].err, 1'b0);
      check("b2b first latency", ev_q[0].cyc - first_cyc, Latency);
      check("b2b spacing", ev_q[1].cyc - ev_q[0].cyc, FrameBits * T);
    end

    // Short low glitch on an idle line.
    ev_q.delete();
    k = cyc;
    rx_i = 1'b0;
    tick(T / 4);
    rx_i = 1'b1;
    tick(T / 2 + 3 - T / 4);
    check("glitch elapsed", cyc - k, T / 2 + 3);
    check("glitch back to idle", dut.state_q, StIdle);
    tick(12 * T);
    check("glitch pulse count", ev_q.size(), 0);

    // Stop bit low followed by a 3T break.
    ev_q.delete();
    frame_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'h3C >> i);
`ifdef UART_RX_PARITY_EN
    drive_bit(^8'h3C);
`endif
    rx_i = 1'b0;
    tick(3 * T);
    rx_i = 1'b1;
    tick(3 * T);
    check("break pulse count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      check("break err flag", ev_q[0].err, 1'b1);
      check("break held data", ev_q[0].data, 8'hFF);
      check("break latency", ev_q[0].cyc - frame_start, Latency);
    end
    check("break data after", rx_data_o, 8'hFF);

    // Reset in the middle of data bit 4; the sender abandons the frame too,
    // so its remaining bits cannot look like a fresh start edge.
    ev_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
    rx_i = 1'b1;
    tick(T / 2);
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    tick(T / 2 + 12 * T);
    check("reset-abort pulse count", ev_q.size(), 0);
    check("reset-abort data cleared", rx_data_o, 8'h00);
    send_frame(8'h81, 1'b1, 1'b0);
    rx_i = 1'b1;
    tick(2 * T);
    check("after reset pulse count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      check("after reset err flag", ev_q[0].err, 1'b0);
      check("after reset data", ev_q[0].data, 8'h81);
    end

    // Randomized frames against the frame-level model.
    ev_q.delete();
    exp_q.delete();
    last_good = 8'h81;
    for (int f = 0; f < 24; f++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      flip    = ($urandom_range(0, 3) == 0);
`else
      flip    = 1'b0;
`endif
      send_frame(d, stop_ok, flip);
      rx_i = 1'b1;
      tick(stop_ok ? $urandom_range(0, 2 * T) : $urandom_range(T, 2 * T));
      if (!stop_ok || flip) begin
        exp_q.push_back('{err: 1'b1, data: last_good});
      end else begin
        exp_q.push_back('{err: 1'b0, data: d});
        last_good = d;
      end
    end
    tick(2 * T);
    check("random pulse count", ev_q.size(), exp_q.size());
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("random%0d err flag", i), ev_q[i].err, exp_q[i].err);
      check($sformatf("random%0d data", i), ev_q[i].data, exp_q[i].data);
    end

    check("valid and err never together", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
